// File: rtl/factorial_inverse_pkg.sv
// Shared definitions for the factorial inverse search: FSM states and parameter defaults.
package factorial_inverse_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    localparam int W_DEFAULT  = 16;
    localparam int NW_DEFAULT = 4;

    // Largest n the search may report for an NW-bit result.
    function automatic int kmax_of(input int nw);
        return (1 << nw) - 1;
    endfunction

endpackage

// File: rtl/factorial_inverse_mul_step.sv
// One search step of the factorial inverse: next running product prod*(k+1), W+NW bits wide.
module factorial_inverse_mul_step
    import factorial_inverse_pkg::*;
#(
    parameter int W  = W_DEFAULT,
    parameter int NW = NW_DEFAULT
) (
    input  logic [W+NW-1:0] prod,
    input  logic [NW:0]     mult,
    output logic [W+NW-1:0] prod_next
);

    // Only used while prod < target < 2**W and mult <= 2**NW, so the result fits W+NW bits.
    assign prod_next = prod * (W+NW)'(mult);

endmodule

// File: rtl/factorial_inverse.sv
// Finds n with n! == fact_in, or the largest n with n! < fact_in, one multiply step per clock.
// Optional FACTINV_FLOOR_EN adds floor_fact = n_out! updated together with done.
module factorial_inverse
    import factorial_inverse_pkg::*;
#(
    parameter int W  = W_DEFAULT,
    parameter int NW = NW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [W-1:0]  fact_in,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] n_out,
    output logic          exact
`ifdef FACTINV_FLOOR_EN
    ,
    output logic [W-1:0]  floor_fact
`endif
);

    localparam logic [NW-1:0] KMAX = NW'(kmax_of(NW));

    state_t           state;
    logic [W-1:0]     target;
    logic [W+NW-1:0]  target_ext;
    logic [W+NW-1:0]  prod;
    logic [W+NW-1:0]  prod_next;
    logic [NW-1:0]    k;
    logic [NW:0]      kp1;
    logic             accept;
    logic             step;
`ifdef FACTINV_FLOOR_EN
    logic [W-1:0]     prev;
`endif

    assign target_ext = {{NW{1'b0}}, target};
    assign kp1        = {1'b0, k} + (NW+1)'(1);
    assign accept     = (state == IDLE) && start;
    assign step       = (state == CALC) && (prod < target_ext) && (k != KMAX);

    factorial_inverse_mul_step #(
        .W  (W),
        .NW (NW)
    ) u_mul_step (
        .prod      (prod),
        .mult      (kp1),
        .prod_next (prod_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            n_out <= '0;
            exact <= 1'b0;
            k     <= '0;
`ifdef FACTINV_FLOOR_EN
            floor_fact <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (prod == target_ext) begin
                        n_out <= k;
                        exact <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
`ifdef FACTINV_FLOOR_EN
                        floor_fact <= prod[W-1:0];
`endif
                    end else if (prod > target_ext) begin
                        // Overshot: the previous n is the floor; value 0 still reports n=0.
                        n_out <= (k == '0) ? '0 : k - 1'b1;
                        exact <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
`ifdef FACTINV_FLOOR_EN
                        floor_fact <= prev;
`endif
                    end else if (k == KMAX) begin
                        n_out <= k;
                        exact <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
`ifdef FACTINV_FLOOR_EN
                        floor_fact <= prod[W-1:0];
`endif
                    end else begin
                        k <= kp1[NW-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; they are always loaded on accept before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            target <= fact_in;
            prod   <= (W+NW)'(1);
`ifdef FACTINV_FLOOR_EN
            prev   <= W'(1);
`endif
        end else if (step) begin
            prod <= prod_next;
`ifdef FACTINV_FLOOR_EN
            prev <= prod[W-1:0];
`endif
        end
    end

endmodule
